// File: rtl/board_writer.sv
// Tic-tac-toe board keeper: accepts one move per turn, rejects bad moves,
// then spends one CHECK cycle scoring the updated board for a win or draw.
module board_writer #(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_new_game,
  input  logic        i_move_valid,
  input  logic [3:0]  i_move_cell,
  output logic        o_move_ready,
  output logic [17:0] o_board,
  output logic        o_turn,
  output logic        o_illegal,
  output logic [1:0]  o_winner,
  output logic        o_draw,
  output logic        o_game_over
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [8:0][1:0] r_cells;
  logic            r_turn;
  logic            r_illegal;
  logic [1:0]      r_winner;
  logic            r_draw;

  logic            w_offer;
  logic            w_target_empty;
  logic            w_accept;
  logic            w_reject;
  logic [8:0]      w_cell_we;
  logic [7:0][1:0] w_lines;
  logic [1:0]      w_line_winner;
  logic            w_full;

  function automatic logic [1:0] line_owner(input logic [1:0] a,
                                            input logic [1:0] b,
                                            input logic [1:0] c);
    return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
  endfunction

  // An out-of-range cell never matches any k, so it reads as occupied.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch,
    // so no path through the block can infer a latch.
    w_target_empty = 1'b0;
    w_cell_we      = '0;
    for (int k = 0; k < 9; k++) begin
      if (i_move_cell == 4'(k)) w_target_empty = (r_cells[k] == 2'b00);
    end
    w_offer  = i_move_valid && (r_state == S_PLAY);
    w_accept = w_offer && w_target_empty;
    w_reject = w_offer && !w_target_empty;
    for (int k = 0; k < 9; k++) begin
      w_cell_we[k] = w_accept && (i_move_cell == 4'(k));
    end
  end

  always_comb begin
    w_lines[0] = line_owner(r_cells[0], r_cells[1], r_cells[2]);
    w_lines[1] = line_owner(r_cells[3], r_cells[4], r_cells[5]);
    w_lines[2] = line_owner(r_cells[6], r_cells[7], r_cells[8]);
    w_lines[3] = line_owner(r_cells[0], r_cells[3], r_cells[6]);
    w_lines[4] = line_owner(r_cells[1], r_cells[4], r_cells[7]);
    w_lines[5] = line_owner(r_cells[2], r_cells[5], r_cells[8]);
    w_lines[6] = line_owner(r_cells[0], r_cells[4], r_cells[8]);
    w_lines[7] = line_owner(r_cells[2], r_cells[4], r_cells[6]);
    w_line_winner = 2'b00;
    w_full        = 1'b1;
    for (int l = 0; l < 8; l++) begin
      if (w_line_winner == 2'b00) w_line_winner = w_lines[l];
    end
    for (int k = 0; k < 9; k++) begin
      if (r_cells[k] == 2'b00) w_full = 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_PLAY:  if (w_accept) w_state_next = S_CHECK;
      S_CHECK: w_state_next = (w_line_winner != 2'b00 || w_full) ? S_OVER : S_PLAY;
      S_OVER:  w_state_next = S_OVER;
      default: w_state_next = S_PLAY;
    endcase
  end

  // new_game clears exactly what rst clears, so the two share one branch.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_new_game) begin
      // NOTE: the cell array is reset explicitly because the board must read
      // all-empty on the first cycle after reset; it is not scratch storage.
      r_cells   <= '0;
      r_state   <= S_PLAY;
      r_turn    <= FIRST_PLAYER;
      r_illegal <= 1'b0;
      r_winner  <= 2'b00;
      r_draw    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_illegal <= w_reject;
      for (int k = 0; k < 9; k++) begin
        if (w_cell_we[k]) r_cells[k] <= {r_turn, ~r_turn};
      end
      if (w_accept) r_turn <= ~r_turn;
      if (r_state == S_CHECK) begin
        r_winner <= w_line_winner;
        r_draw   <= (w_line_winner == 2'b00) && w_full;
      end
    end
  end

  assign o_move_ready = (r_state == S_PLAY);
  assign o_board      = r_cells;
  assign o_turn       = r_turn;
  assign o_illegal    = r_illegal;
  assign o_winner     = r_winner;
  assign o_draw       = r_draw;
  assign o_game_over  = (r_winner != 2'b00) || r_draw;

endmodule

// File: tb/tb_board_writer.sv
// Bench for board_writer: directed game scenarios followed by random play,
// every cycle compared against a cell-array game model.
module tb_board_writer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_new_game = 1'b0;
  logic        i_move_valid = 1'b0;
  logic [3:0]  i_move_cell = 4'd0;
  logic        o_move_ready;
  logic [17:0] o_board;
  logic        o_turn;
  logic        o_illegal;
  logic [1:0]  o_winner;
  logic        o_draw;
  logic        o_game_over;

  board_writer #(.FIRST_PLAYER(1'b0)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_new_game   (i_new_game),
    .i_move_valid (i_move_valid),
    .i_move_cell  (i_move_cell),
    .o_move_ready (o_move_ready),
    .o_board      (o_board),
    .o_turn       (o_turn),
    .o_illegal    (o_illegal),
    .o_winner     (o_winner),
    .o_draw       (o_draw),
    .o_game_over  (o_game_over)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Game model: cells hold 0 empty, 1 X, 2 O; scoring happens one cycle
  // after a move lands (m_scoring), during which no move is taken.
  int m_cell [9];
  int m_turn;
  int m_winner;
  int m_draw;
  int m_illegal;
  int m_scoring;
  int win_lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                           '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic logic [17:0] model_board();
    logic [17:0] b = '0;
    for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(m_cell[k]);
    return b;
  endfunction

  function automatic int model_over();
    return (m_winner != 0 || m_draw != 0) ? 1 : 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 9; k++) m_cell[k] = 0;
    m_turn = 0; m_winner = 0; m_draw = 0; m_illegal = 0; m_scoring = 0;
  endtask

  task automatic model_edge(input bit v, input int c, input bit ng, input bit r);
    int ready;
    int full;
    ready = (model_over() == 0 && m_scoring == 0) ? 1 : 0;
    if (r || ng) begin
      model_clear();
      return;
    end
    m_illegal = 0;
    if (m_scoring != 0) begin
      m_scoring = 0;
      full = 1;
      for (int k = 0; k < 9; k++) if (m_cell[k] == 0) full = 0;
      for (int l = 0; l < 8; l++) begin
        if (m_winner == 0 && m_cell[win_lines[l][0]] != 0 &&
            m_cell[win_lines[l][0]] == m_cell[win_lines[l][1]] &&
            m_cell[win_lines[l][1]] == m_cell[win_lines[l][2]])
          m_winner = m_cell[win_lines[l][0]];
      end
      if (m_winner == 0 && full != 0) m_draw = 1;
    end else if (ready != 0 && v) begin
      if (c > 8 || m_cell[c] != 0) begin
        m_illegal = 1;
      end else begin
        m_cell[c] = m_turn + 1;
        m_turn    = 1 - m_turn;
        m_scoring = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("board",     32'(o_board),      32'(model_board()));
    check("turn",      32'(o_turn),       32'(m_turn));
    check("illegal",   32'(o_illegal),    32'(m_illegal));
    check("winner",    32'(o_winner),     32'(m_winner));
    check("draw",      32'(o_draw),       32'(m_draw));
    check("game_over", 32'(o_game_over),  32'(model_over()));
    check("ready",     32'(o_move_ready),
          32'((model_over() == 0 && m_scoring == 0) ? 1 : 0));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input bit v, input int c, input bit ng, input bit r);
    i_move_valid = v;
    i_move_cell  = c[3:0];
    i_new_game   = ng;
    i_rst        = r;
    @(posedge i_clk);
    model_edge(v, c, ng, r);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  // Accepted move plus its scoring cycle.
  task automatic move(input int c);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int seq [9];
    model_clear();

    // Row-0 win for X.
    do_reset();
    check("rst_ready", 32'(o_move_ready), 32'd1);
    check("rst_board", 32'(o_board), 32'd0);
    move(0); move(3); move(1); move(4);
    step(1'b1, 2, 1'b0, 1'b0);
    check("xrow_cells012", 32'(o_board[5:0]), 32'h15);
    check("xrow_cells34",  32'(o_board[9:6]), 32'hA);
    step(1'b0, 0, 1'b0, 1'b0);
    check("xrow_winner", 32'(o_winner), 32'd1);
    check("xrow_over",   32'(o_game_over), 32'd1);
    check("xrow_ready",  32'(o_move_ready), 32'd0);

    // Occupied cell, then out-of-range cell.
    do_reset();
    move(4);
    step(1'b1, 4, 1'b0, 1'b0);
    check("ill_occupied", 32'(o_illegal), 32'd1);
    step(1'b1, 9, 1'b0, 1'b0);
    check("ill_range", 32'(o_illegal), 32'd1);
    step(1'b0, 0, 1'b0, 1'b0);
    check("ill_pulse_end", 32'(o_illegal), 32'd0);
    check("ill_cell4", 32'(o_board[9:8]), 32'h1);
    check("ill_turn",  32'(o_turn), 32'd1);

    // Draw, then a move offered in OVER.
    do_reset();
    seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    foreach (seq[i]) move(seq[i]);
    check("draw_flag",   32'(o_draw), 32'd1);
    check("draw_winner", 32'(o_winner), 32'd0);
    check("draw_over",   32'(o_game_over), 32'd1);
    step(1'b1, 0, 1'b0, 1'b0);
    check("draw_no_ill", 32'(o_illegal), 32'd0);

    // Ninth move completes column 0: win beats draw.
    do_reset();
    seq = '{0, 1, 2, 4, 3, 5, 7, 8, 6};
    foreach (seq[i]) move(seq[i]);
    check("win9_winner", 32'(o_winner), 32'd1);
    check("win9_draw",   32'(o_draw), 32'd0);

    // new_game drops a concurrent move; rst lands mid-CHECK.
    do_reset();
    move(1);
    step(1'b1, 5, 1'b1, 1'b0);
    check("ng_board", 32'(o_board), 32'd0);
    check("ng_turn",  32'(o_turn), 32'd0);
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b1);
    check("rst_check_board", 32'(o_board), 32'd0);
    check("rst_check_ready", 32'(o_move_ready), 32'd1);

    // move_valid held through CHECK: one write, then flagged illegal.
    do_reset();
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 1'b0);
    check("stall_no_ill", 32'(o_illegal), 32'd0);
    step(1'b1, 4, 1'b0, 1'b0);
    check("stall_reoffer", 32'(o_illegal), 32'd1);
    check("stall_board", 32'(o_board), 32'h100);

    // Random play with occasional new_game and rst.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int c;
      c = ($urandom % 8 == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      step(1'($urandom % 2), c, 1'($urandom % 40 == 0), 1'($urandom % 300 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
